dac_spi_tx: RTL

Downstream stage of the FIR: takes each filtered sample from `fir.data_out` and shifts it as a 16-bit SPI frame into an external 10-bit serial DAC (MCP49x1-style command word). The block owns the SPI timing, the chip-select framing and the optional LDAC latch pulse. It accepts one sample per frame through a valid/ready handshake. No buffering: a sample offered while busy is dropped and flagged.

---
 rtl/dac_pkg.sv | 38 +++
 rtl/spi_tick_gen.sv | 54 +++++
 rtl/dac_spi_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
//
// Shared definitions for the serial DAC transmitter (dac_spi_tx):
//   - dac_state_t : transmitter FSM state encoding
//   - FRAME_W     : bits per SPI frame sent to the DAC (16)
//   - DATA_W      : width of the DAC data field inside the frame (12)
//   - CFG_DEFAULT : default command nibble {A/B, BUF, GA_n, SHDN_n}
//   - build_frame : assembles the 16-bit command word from nibble + sample
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned DATA_W  = 12;

    // Channel A, buffered reference, 1x gain, output active.
    localparam logic [3:0] CFG_DEFAULT = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_LDAC  = 3'd4
    } dac_state_t;

    // The sample (zero-extended to DATA_W bits) is left-aligned inside the
    // 12-bit data field, so a narrower converter simply sees its MSBs and the
    // unused low bits go out as zeros.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [3:0]        cfg,
        input logic [DATA_W-1:0] sample,
        input int unsigned       sample_w
    );
        return {cfg, sample << (DATA_W - sample_w)};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
//
// Clock divider for the SPI engine. Emits a one-cycle tick every clk_div
// system clocks; restart_i clears the count so the first tick after a frame
// is accepted lands exactly clk_div cycles later.
//
// Parameters:
//   clk_div   : system clocks between ticks (>= 1)
// Ports:
//   clk_i     : system clock
//   rst_i     : asynchronous active-high reset
//   restart_i : synchronous restart of the divider count
//   tick_o    : one-cycle pulse, high when the count reaches clk_div-1
// -----------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int unsigned clk_div = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    // At least one counter bit, even when clk_div is 1 and the tick is
    // permanently asserted.
    localparam int unsigned CW = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [CW-1:0] LAST = CW'(clk_div - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//
// Shifts each accepted sample into an MCP49x1-style serial DAC as a 16-bit
// SPI mode-0 frame {config_bits, left-aligned 12-bit data field}, MSB first.
// One sample per frame via valid/ready; samples offered while busy are
// dropped and flagged on overrun.
//
// Frame timeline (C = clk_div, accept edge at the end of cycle T0):
//   SETUP  : C cycles, cs_n low, sclk low, first bit already on mosi
//   SHIFT  : 16 bits of (C cycles sclk high, C cycles sclk low); the DAC
//            samples on sclk rising, mosi advances on sclk falling
//   HOLD   : C cycles with sclk low before cs_n rises
//   LDAC   : C cycles of ldac_n low (only with DAC_SPI_LDAC_EN)
//   IDLE   : ready high; a new sample can be accepted immediately
//
// Optional feature macro: DAC_SPI_LDAC_EN
//   defined   : LDAC state built, ldac_n idles high and pulses low after cs_n
//               rises; ready returns clk_div cycles later
//   undefined : ldac_n tied low, DAC updates on the cs_n rising edge
//
// Parameters:
//   width       : sample width, 1..12
//   clk_div     : system clocks per SCLK half-period, >= 1
//   config_bits : DAC command nibble
// Ports:
//   clock      : system clock
//   reset      : asynchronous active-high reset (aborts a frame in flight)
//   data_in    : unsigned straight-binary sample
//   data_valid : data_in valid this cycle
//   ready      : idle, a sample will be accepted this cycle
//   overrun    : data_valid seen while not ready (sample dropped)
//   sclk       : SPI clock, idle low
//   mosi       : SPI data, low whenever cs_n is high
//   cs_n       : DAC chip select, active low
//   ldac_n     : DAC latch strobe, active low
// -----------------------------------------------------------------------------
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int unsigned width       = 10,
    parameter int unsigned clk_div     = 4,
    parameter logic [3:0]  config_bits = CFG_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] data_in,
    input  logic             data_valid,
    output logic             ready,
    output logic             overrun,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic             ldac_n
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_W - 1);

    dac_state_t         state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_q,   bit_d;
    // 0: high half of the current bit, 1: low half.
    logic               phase_q, phase_d;

    // Pin drivers are registered from next-state so the SPI lines are
    // glitch-free and still change in the same cycle the state does.
    logic ready_q, ready_d;
    logic sclk_q,  sclk_d;
    logic mosi_q,  mosi_d;
    logic cs_n_q,  cs_n_d;

    logic               accept;
    logic               tick;
    logic [DATA_W-1:0]  sample_ext;
    logic [FRAME_W-1:0] frame_w;

    assign accept     = (state_q == ST_IDLE) && data_valid;
    assign sample_ext = DATA_W'(data_in);
    assign frame_w    = build_frame(config_bits, sample_ext, width);

    spi_tick_gen #(
        .clk_div (clk_div)
    ) u_tick (
        .clk_i     (clock),
        .rst_i     (reset),
        .restart_i (accept),
        .tick_o    (tick)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        phase_d = phase_q;

        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    state_d = ST_SETUP;
                    shift_d = frame_w;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end

            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        // Falling sclk: present the next bit, except after the
                        // last one, which stays on mosi until cs_n rises.
                        phase_d = 1'b1;
                        if (bit_q != LAST_BIT) begin
                            shift_d = shift_q << 1;
                        end
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        phase_d = 1'b0;
                    end
                end
            end

            ST_HOLD: begin
                if (tick) begin
`ifdef DAC_SPI_LDAC_EN
                    state_d = ST_LDAC;
`else
                    state_d = ST_IDLE;
`endif
                end
            end

            ST_LDAC: begin
`ifdef DAC_SPI_LDAC_EN
                if (tick) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from next state
    // -------------------------------------------------------------------------
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        cs_n_d  = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                    (state_d == ST_HOLD));
        sclk_d  = (state_d == ST_SHIFT) && !phase_d;
        // mosi is forced low outside the chip-select window.
        mosi_d  = !cs_n_d && shift_d[FRAME_W-1];
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            ready_q <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

`ifdef DAC_SPI_LDAC_EN
    logic ldac_n_q;
    logic ldac_n_d;

    assign ldac_n_d = (state_d != ST_LDAC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ldac_n_q <= 1'b1;
        end else begin
            ldac_n_q <= ldac_n_d;
        end
    end

    assign ldac_n = ldac_n_q;
`else
    // Without a latch pulse the DAC transfers on the cs_n rising edge.
    assign ldac_n = 1'b0;
`endif

    assign ready   = ready_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    // Combinational so the flag lines up with the dropped sample's cycle.
    assign overrun = data_valid && !ready_q;

endmodule
